// File: rtl/bank_request_router.sv
// Routes host requests to NUM_BANKS single-port banks through a registered strobe stage
// and returns read data in request order through a first-word-fall-through response FIFO.
module bank_request_router #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 4,
  parameter int INTERLEAVE = 0,
  parameter int RSP_DEPTH  = 4,
  localparam int SEL_W     = $clog2(NUM_BANKS),
  localparam int LOCAL_W   = ADDR_WIDTH - SEL_W
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  // Request handshake: a request transfers on a rising edge where i_req_valid and
  // o_req_ready are both high; o_req_ready never depends on i_req_valid or i_rready.
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic                            i_req_we,
  input  logic [ADDR_WIDTH-1:0]           i_address,
  input  logic [DATA_WIDTH-1:0]           i_wdata,
  output logic [NUM_BANKS-1:0]            o_bank_en,
  output logic                            o_bank_we,
  output logic [LOCAL_W-1:0]              o_bank_addr,
  output logic [DATA_WIDTH-1:0]           o_bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata,
  output logic                            o_rvalid,
  input  logic                            i_rready,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);

  logic [SEL_W-1:0]      w_sel;
  logic [LOCAL_W-1:0]    w_local;
  logic [NUM_BANKS-1:0]  w_onehot;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [CNT_W:0]        w_inflight;
  logic [DATA_WIDTH-1:0] w_rdata_arr [NUM_BANKS];

  logic [NUM_BANKS-1:0]  r_bank_en;
  logic                  r_bank_we;
  logic [LOCAL_W-1:0]    r_bank_addr;
  logic [DATA_WIDTH-1:0] r_bank_wdata;
  logic                  r_s1_read;
  logic [SEL_W-1:0]      r_s1_bank;
  logic                  r_s1_read_d;
  logic [SEL_W-1:0]      r_s1_bank_d;

  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  generate
    if (INTERLEAVE == 0) begin : g_high_order
      assign w_sel   = i_address[ADDR_WIDTH-1 -: SEL_W];
      assign w_local = i_address[LOCAL_W-1:0];
    end else begin : g_low_order
      assign w_sel   = i_address[SEL_W-1:0];
      assign w_local = i_address[ADDR_WIDTH-1:SEL_W];
    end
  endgenerate

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  genvar k;
  generate
    for (k = 0; k < NUM_BANKS; k++) begin : g_rdata
      assign w_rdata_arr[k] = i_bank_rdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Every read in a pipeline stage already owns a FIFO slot, so gating reads on the
  // total in-flight count makes overflow impossible without looking at i_rready.
  assign w_inflight  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_read} + {{CNT_W{1'b0}}, r_s1_read_d};
  assign o_req_ready = i_req_we | (w_inflight < DEPTH_C);
  assign w_accept    = i_req_valid & o_req_ready;

  assign w_empty = (r_count == '0);
  assign w_push  = r_s1_read_d;
  assign w_pop   = ~w_empty & i_rready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_en    <= '0;
      r_bank_we    <= 1'b0;
      r_bank_addr  <= '0;
      r_bank_wdata <= '0;
      r_s1_read    <= 1'b0;
      r_s1_bank    <= '0;
      r_s1_read_d  <= 1'b0;
      r_s1_bank_d  <= '0;
    end else begin
      r_bank_en   <= w_accept ? w_onehot : '0;
      r_s1_read   <= w_accept & ~i_req_we;
      r_s1_read_d <= r_s1_read;
      r_s1_bank_d <= r_s1_bank;
      if (w_accept) begin
        r_bank_we    <= i_req_we;
        r_bank_addr  <= w_local;
        r_bank_wdata <= i_wdata;
        r_s1_bank    <= w_sel;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_rdata_arr[r_s1_bank_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_bank_en    = r_bank_en;
  assign o_bank_we    = r_bank_we;
  assign o_bank_addr  = r_bank_addr;
  assign o_bank_wdata = r_bank_wdata;
  assign o_rvalid     = ~w_empty;
  assign o_rdata      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_busy       = r_s1_read | r_s1_read_d | ~w_empty;

endmodule

// File: tb/tb_bank_request_router.sv
// Directed bench for bank_request_router: one high-order and one interleaved instance
// share the request/bank stimulus; responses of the high-order instance go through a scoreboard.
module tb_bank_request_router;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_we;
  logic [AW-1:0]  address;
  logic [DW-1:0]  wdata;
  logic [NB*DW-1:0] bank_rdata;
  logic           rready;

  logic           ready0, we0, rvalid0, busy0;
  logic [NB-1:0]  en0;
  logic [3:0]     addr0;
  logic [DW-1:0]  wdata0, rdata0;
  logic           ready1, we1, rvalid1, busy1;
  logic [NB-1:0]  en1;
  logic [3:0]     addr1;
  logic [DW-1:0]  wdata1, rdata1;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_count = 0;
  logic [DW-1:0] exp_q[$];

  logic [AW-1:0] ord_addr [4] = '{6'b00_0011, 6'b11_0111, 6'b01_1000, 6'b10_1111};
  logic [DW-1:0] ord_exp  [4] = '{8'h10, 8'h13, 8'h11, 8'h12};
  logic [AW-1:0] bp_addr  [4] = '{6'b01_0001, 6'b10_0010, 6'b11_0011, 6'b00_0100};
  logic [DW-1:0] bp_exp   [4] = '{8'h21, 8'h22, 8'h23, 8'h20};

  always #5 clk = ~clk;

  bank_request_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .INTERLEAVE(0), .RSP_DEPTH(DEPTH)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready0),
    .i_req_we(req_we), .i_address(address), .i_wdata(wdata),
    .o_bank_en(en0), .o_bank_we(we0), .o_bank_addr(addr0), .o_bank_wdata(wdata0),
    .i_bank_rdata(bank_rdata), .o_rvalid(rvalid0), .i_rready(rready), .o_rdata(rdata0), .o_busy(busy0)
  );

  bank_request_router #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .INTERLEAVE(1), .RSP_DEPTH(DEPTH)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(ready1),
    .i_req_we(req_we), .i_address(address), .i_wdata(wdata),
    .o_bank_en(en1), .o_bank_we(we1), .o_bank_addr(addr1), .o_bank_wdata(wdata1),
    .i_bank_rdata(bank_rdata), .o_rvalid(rvalid1), .i_rready(rready), .o_rdata(rdata1), .o_busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    address   = a;
    wdata     = d;
  endtask

  task automatic set_banks(input logic [DW-1:0] base);
    for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = base + DW'(b);
  endtask

  // Scoreboard: every pop of the high-order instance must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rvalid0 && rready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {24'd0, rdata0}, 32'hFFFF_FFFF);
      else check("rsp_data", {24'd0, rdata0}, {24'd0, exp_q.pop_front()});
      rsp_count++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && dut0.r_s1_read_d) check("push_when_full", 32'(dut0.r_count == 3'(DEPTH)), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n  = 1'b0;
    rready = 1'b1;
    bank_rdata = '0;
    drive(1'b0, 1'b0, '0, '0);

    // Reset state
    step(); step();
    check("rst_ready", ready0, 1);
    check("rst_en", en0, 0);
    check("rst_rvalid", rvalid0, 0);
    check("rst_busy", busy0, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", ready0, 1);
    check("post_rst_rvalid", rvalid0, 0);
    check("post_rst_busy", busy0, 0);

    // Write decode, both select modes
    set_banks(8'hE0);
    drive(1'b1, 1'b1, 6'b10_0101, 8'hA5);
    #1 check("wr_ready", ready0, 1);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("wr_en0", en0, 4'b0100);
    check("wr_addr0", addr0, 4'b0101);
    check("wr_we0", we0, 1);
    check("wr_wdata0", wdata0, 8'hA5);
    check("wr_en1", en1, 4'b0010);
    check("wr_addr1", addr1, 4'b1001);
    step();
    check("wr_strobe_end", en0, 0);
    check("wr_we_hold", we0, 1);
    check("wr_no_rsp", rvalid0, 0);
    step();
    check("wr_no_rsp2", rvalid0, 0);
    check("wr_idle", busy0, 0);

    // Interleaved read: bank 1 returns 3C; high-order instance reads bank 2 (3D)
    set_banks(8'h3B);
    drive(1'b1, 1'b0, 6'b10_0101, 8'h00);
    exp_q.push_back(8'h3D);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("il_en", en1, 4'b0010);
    check("il_addr", addr1, 4'b1001);
    check("il_we", we1, 0);
    check("il_rvalid_e0", rvalid1, 0);
    check("il_busy", busy1, 1);
    step();
    check("il_rvalid_e1", rvalid1, 0);
    step();
    check("il_rvalid_e2", rvalid1, 1);
    check("il_rdata", rdata1, 8'h3C);
    step();
    check("il_drained", rvalid1, 0);
    check("il_idle", busy1, 0);

    // Ordering: back-to-back reads of banks 0,3,1,2
    set_banks(8'h10);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, ord_addr[i], 8'h00);
      exp_q.push_back(ord_exp[i]);
      step();
      check("ord_rvalid", rvalid0, (i >= 2) ? 1 : 0);
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
    check("ord_rvalid_e4", rvalid0, 1);
    step();
    check("ord_rvalid_e5", rvalid0, 1);
    step();
    check("ord_rvalid_e6", rvalid0, 0);
    check("ord_idle", busy0, 0);

    // Backpressure: fill to depth with consumer stalled
    rready = 1'b0;
    set_banks(8'h20);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, bp_addr[i], 8'h00);
      #1 check("bp_ready_open", ready0, 1);
      exp_q.push_back(bp_exp[i]);
      step();
    end
    drive(1'b1, 1'b0, 6'b01_1111, 8'h00);
    #1 check("bp_ready_low", ready0, 0);
    step();
    check("bp_no_strobe", en0, 0);
    step();
    check("bp_ready_held", ready0, 0);
    check("bp_rvalid", rvalid0, 1);
    drive(1'b1, 1'b1, 6'b11_0000, 8'h77);
    #1 check("bp_write_ready", ready0, 1);
    step();
    drive(1'b0, 1'b0, '0, '0);
    check("bp_write_en", en0, 4'b1000);
    check("bp_write_we", we0, 1);
    base = rsp_count;
    rready = 1'b1;
    for (int c = 0; c < 20 && rvalid0; c++) step();
    check("bp_drain_done", rvalid0, 0);
    check("bp_drain_count", rsp_count - base, 4);
    #1 check("bp_ready_back", ready0, 1);
    check("bp_idle", busy0, 0);

    // Reset one cycle after a read is accepted
    set_banks(8'h40);
    drive(1'b1, 1'b0, 6'b10_0000, 8'h00);
    step();
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rvalid", rvalid0, 0);
    check("mid_rst_en", en0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_no_rsp", rvalid0, 0);
      check("mid_rst_idle", busy0, 0);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
